wrr_input_arbiter_n: RTL
========================

Name: wrr_input_arbiter_n

Overview:
Parametrised weighted round-robin input arbiter for the user data path, for NUM_QUEUES rx queues. Each queue is buffered in an internal FIFO. The arbiter grants a queue up to weight[i] whole packets per turn, then moves to the next eligible queue. Packets are never interleaved. Weights are run-time inputs driven from the register block and are not constants. The output is a single registered data/ctrl/wr stream with out_rdy backpressure, feeding output_port_lookup.

Parameters:
DATA_WIDTH, 64, data word width
CTRL_WIDTH, DATA_WIDTH/8, ctrl word width
NUM_QUEUES, 8, number of input queues (2..16)
QW, log2(NUM_QUEUES) (min 1), queue index width
WEIGHT_WIDTH, 8, per-queue weight width; weight unit is one packet
FIFO_DEPTH_BITS, 2, per-queue FIFO depth = 2**FIFO_DEPTH_BITS words

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_data  in  NUM_QUEUES*DATA_WIDTH  queue i data at [i*DATA_WIDTH +: DATA_WIDTH]
in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  queue i ctrl, same packing
in_wr  in  NUM_QUEUES  per-queue write strobe
in_rdy  out  NUM_QUEUES  per-queue ready (FIFO not nearly full)
weight  in  NUM_QUEUES*WEIGHT_WIDTH  per-queue weight; 0 = queue disabled
out_data  out  DATA_WIDTH  output data
out_ctrl  out  CTRL_WIDTH  output ctrl
out_wr  out  1  output write strobe
out_rdy  in  1  downstream ready
cur_queue  out  QW  currently granted queue
eop  out  1  one-cycle pulse when the last word of a packet is written

Behaviour:
- Reset (reset_n low, asynchronous):
  - all FIFOs flushed; state = SELECT; cur_queue = NUM_QUEUES-1, so the first scan starts at queue 0; credit = 0.
  - outputs: out_wr=0, out_ctrl=0, out_data=0, eop=0.
  - in_rdy: all 1 once reset is released. Reset mid-packet discards the partial packet; no completion is emitted.
- FIFOs:
  - nearly_full is asserted when occupancy >= depth-1; in_rdy[i] = !nearly_full[i].
  - A write while the FIFO is full is dropped; this is a sender protocol violation.
  - Simultaneous read and write keeps occupancy constant.
- Packet framing:
  - A packet is one or more header words (ctrl != 0), then one or more body words (ctrl == 0).
  - The packet ends with the first word whose ctrl != 0 that follows a ctrl == 0 word. That word is the last word and is transmitted.
  - Tracking: register prev_ctrl_zero, set to 0 at packet start.
- State SELECT (one cycle per decision):
  - Eligible queue: FIFO not empty and weight != 0.
  - If credit > 0 and cur_queue is eligible: stay on it and go to WR_PKT.
  - Otherwise: scan cyclically cur_queue+1 .. cur_queue (wrapping modulo NUM_QUEUES) for the first eligible queue. Set cur_queue to it, load credit = weight[that queue], go to WR_PKT.
  - If no queue is eligible: remain in SELECT, keep cur_queue, credit = 0.
  - A weight change affects only the next credit load.
- State WR_PKT:
  - Each cycle where out_rdy=1 and the granted FIFO is non-empty: pop one word, register it to out_data/out_ctrl, and set out_wr=1 in the next cycle.
  - Output latency is 1 cycle from pop.
  - Otherwise out_wr=0 and no pop. Backpressure and FIFO underrun stall the stream indefinitely without leaving the packet.
  - On the last word: eop=1 (aligned with that word's out_wr); credit = credit-1, saturating at 0; return to SELECT.
  - No bubble is required beyond the single SELECT cycle between packets.
- Arithmetic:
  - credit is WEIGHT_WIDTH bits.
  - Scan is a priority search with wrap-around; any NUM_QUEUES that is not a power of two wraps at NUM_QUEUES-1, never at 2**QW-1.
- Rounds:
  - A queue that empties while credit > 0 forfeits the remaining credit at the next SELECT.
  - A queue whose weight becomes 0 mid-packet finishes the current packet, then is skipped.
- Invariants:
  - out_wr never asserts while out_rdy was low in the popping cycle.
  - Words of different packets are never interleaved.

Test Plan:
- Reset and idle: reset_n low with in_wr active -> out_wr=0 and eop=0; after release, in_rdy = all 1s and cur_queue = NUM_QUEUES-1.
- Equal weights: weight=1 for all queues, 4-word packets preloaded on queues 0, 3 and 5 -> packets output in order 0, 3, 5; eop exactly on the 4th word of each; one SELECT cycle between packets.
- Weighted: weight0=3, weight1=1, queues 0 and 1 continuously backlogged -> output packet sequence 0,0,0,1,0,0,0,1; no word interleaving.
- Disable and wrap: weight2=0 with queue 2 backlogged, only queues 2 and 7 holding packets, cur_queue=6 -> queue 7 served, then the scan wraps, queue 2 is never served, and the arbiter idles in SELECT.
- Backpressure: out_rdy toggling every other cycle mid-packet -> no pop while out_rdy=0; every out_wr follows an out_rdy=1 cycle by 1; word count and order preserved.
- Reset mid-packet: reset_n asserted after word 2 of a 5-word packet -> outputs clear immediately; no eop; after release the FIFOs are empty and the next fresh packet is output intact.

Source files
------------

// File: rtl/wrr_input_arbiter_n.sv
// Weighted round-robin input arbiter.
// Each rx queue feeds a small first-word-fall-through FIFO. The arbiter grants
// one queue at a time for up to weight[i] whole packets, then moves on to the
// next eligible queue in cyclic order. Packets are never interleaved and the
// merged stream is registered toward output_port_lookup.
module wrr_input_arbiter_n #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 8,
    parameter int QW              = (NUM_QUEUES > 2) ? $clog2(NUM_QUEUES) : 1,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
    input  logic [NUM_QUEUES-1:0]              in_wr,
    output logic [NUM_QUEUES-1:0]              in_rdy,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weight,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,
    output logic [QW-1:0]                      cur_queue,
    output logic                               eop
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int CNT_W  = FIFO_DEPTH_BITS + 1;

    localparam logic [0:0] ST_SELECT = 1'b0;
    localparam logic [0:0] ST_WR_PKT = 1'b1;

    logic [WORD_W-1:0]          fifo_mem   [NUM_QUEUES][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr     [NUM_QUEUES];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr     [NUM_QUEUES];
    logic [CNT_W-1:0]           fifo_count [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] fifo_empty;
    logic [NUM_QUEUES-1:0] fifo_full;
    logic [NUM_QUEUES-1:0] fifo_push;
    logic [NUM_QUEUES-1:0] fifo_pop;
    logic [NUM_QUEUES-1:0] eligible;

    logic [0:0]              state;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic                    prev_ctrl_zero;

    logic                    pop_en;
    logic [WORD_W-1:0]       head_word;
    logic [CTRL_WIDTH-1:0]   head_ctrl;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    head_is_last;

    logic                    scan_found;
    logic [QW-1:0]           scan_queue;
    logic [WEIGHT_WIDTH-1:0] scan_weight;

    // Per-queue FIFO status, write acceptance and arbitration eligibility.
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            fifo_empty[i] = (fifo_count[i] == '0);
            fifo_full[i]  = (fifo_count[i] == CNT_W'(DEPTH));
            in_rdy[i]     = (fifo_count[i] < CNT_W'(DEPTH - 1));
            fifo_push[i]  = in_wr[i] && !fifo_full[i];
            eligible[i]   = !fifo_empty[i] &&
                            (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
        end
    end

    assign pop_en       = (state == ST_WR_PKT) && out_rdy && !fifo_empty[cur_queue];
    assign head_word    = fifo_mem[cur_queue][rd_ptr[cur_queue]];
    assign head_ctrl    = head_word[DATA_WIDTH +: CTRL_WIDTH];
    assign head_data    = head_word[DATA_WIDTH-1:0];
    assign head_is_last = prev_ctrl_zero && (head_ctrl != '0);

    // Only the granted queue's FIFO is ever popped.
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            fifo_pop[i] = pop_en && (cur_queue == QW'(i));
        end
    end

    // Cyclic priority search starting after cur_queue, wrapping at NUM_QUEUES-1.
    always_comb begin
        logic [QW:0]   sum;
        logic [QW-1:0] idx;
        scan_found = 1'b0;
        scan_queue = cur_queue;
        sum        = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            sum = {1'b0, cur_queue} + (QW+1)'(k);
            if (sum >= (QW+1)'(NUM_QUEUES)) begin
                sum = sum - (QW+1)'(NUM_QUEUES);
            end
            idx = sum[QW-1:0];
            if (!scan_found && eligible[idx]) begin
                scan_found = 1'b1;
                scan_queue = idx;
            end
        end
    end

    // Weight of the queue the scan selected, used as the fresh credit.
    always_comb begin
        scan_weight = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (scan_queue == QW'(i)) begin
                scan_weight = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                wr_ptr[i]     <= '0;
                rd_ptr[i]     <= '0;
                fifo_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (fifo_push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + FIFO_DEPTH_BITS'(1);
                end
                if (fifo_pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + FIFO_DEPTH_BITS'(1);
                end
                if (fifo_push[i] && !fifo_pop[i]) begin
                    fifo_count[i] <= fifo_count[i] + CNT_W'(1);
                end else if (!fifo_push[i] && fifo_pop[i]) begin
                    fifo_count[i] <= fifo_count[i] - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage, written {ctrl, data} at the write pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (fifo_push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH],
                                           in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Grant FSM: SELECT picks a queue and credit, WR_PKT streams one whole packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_SELECT;
            cur_queue      <= QW'(NUM_QUEUES - 1);
            credit         <= '0;
            prev_ctrl_zero <= 1'b0;
            out_wr         <= 1'b0;
            out_data       <= '0;
            out_ctrl       <= '0;
            eop            <= 1'b0;
        end else begin
            out_wr <= 1'b0;
            eop    <= 1'b0;
            case (state)
                ST_SELECT: begin
                    if ((credit != '0) && eligible[cur_queue]) begin
                        state          <= ST_WR_PKT;
                        prev_ctrl_zero <= 1'b0;
                    end else if (scan_found) begin
                        cur_queue      <= scan_queue;
                        credit         <= scan_weight;
                        state          <= ST_WR_PKT;
                        prev_ctrl_zero <= 1'b0;
                    end else begin
                        credit <= '0;
                    end
                end
                ST_WR_PKT: begin
                    if (pop_en) begin
                        out_wr         <= 1'b1;
                        out_data       <= head_data;
                        out_ctrl       <= head_ctrl;
                        prev_ctrl_zero <= (head_ctrl == '0);
                        if (head_is_last) begin
                            eop    <= 1'b1;
                            credit <= (credit == '0) ? '0 : credit - WEIGHT_WIDTH'(1);
                            state  <= ST_SELECT;
                        end
                    end
                end
                default: begin
                    state <= ST_SELECT;
                end
            endcase
        end
    end

endmodule
